// File: rtl/addr8s_pkg.sv
// addr8s_pkg
// Shared types and constants for the addr8s_* checker family.
//   ADDR8S_WIDTH / ADDR8S_CNT_W : default operand and counter widths
//   SUM_W                       : adder result width (operand width + 1)
//   CNT_MAX                     : all-ones value of a default-width counter
//   sum_t                       : adder result type at the default width
//   state_t                     : campaign FSM states
package addr8s_pkg;

    localparam int ADDR8S_WIDTH = 8;
    localparam int ADDR8S_CNT_W = 16;

    localparam int SUM_W = ADDR8S_WIDTH + 1;
    localparam logic [ADDR8S_CNT_W-1:0] CNT_MAX = '1;

    typedef logic [SUM_W-1:0] sum_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/addr8s_result_checker_if.sv
// addr8s_result_checker_if
// Bundles the control, operand stream and result/status signals of the
// result checker.
//   master : campaign driver (drives start/target and operand triples)
//   slave  : the checker itself
interface addr8s_result_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();

    logic             start;
    logic [CNT_W-1:0] target;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   dut_sum;
    logic             res_valid;
    logic             res_mismatch;
    logic [WIDTH:0]   res_diff;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_idx;
    logic             busy;
    logic             done;

    modport master (
        output start, target, in_valid, op_a, op_b, dut_sum,
        input  in_ready, res_valid, res_mismatch, res_diff, vec_cnt, err_cnt,
               first_err_valid, first_err_idx, busy, done
    );

    modport slave (
        input  start, target, in_valid, op_a, op_b, dut_sum,
        output in_ready, res_valid, res_mismatch, res_diff, vec_cnt, err_cnt,
               first_err_valid, first_err_idx, busy, done
    );

endinterface

// File: rtl/addr8s_golden_cmp.sv
// addr8s_golden_cmp
// Combinational golden model for a WIDTH-bit signed adder: sign-extends both
// operands to WIDTH+1 bits, adds them (exact, cannot overflow), and compares
// the result against the adder-under-test output.
//   op_a, op_b : signed operands
//   dut_sum    : adder output O[WIDTH:0]
//   diff       : golden XOR dut_sum, one bit per erroneous position
//   mismatch   : any bit of diff set
module addr8s_golden_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   dut_sum,
    output logic [WIDTH:0]   diff,
    output logic             mismatch
);

    logic [WIDTH:0] golden;

    assign golden = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};

    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_diff
        assign diff[gi] = golden[gi] ^ dut_sum[gi];
    end

    assign mismatch = |diff;

endmodule

// File: rtl/addr8s_result_checker.sv
// addr8s_result_checker
// Checks the outputs of an addr8s_* adder against an exact golden sum over a
// bounded campaign of `target` vectors. Accepted triples go through a fixed
// two-stage pipeline (capture, then compare) and each result updates the
// vector/error counters and the first-error log.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/target control, operand stream (in_valid/in_ready,
//                op_a, op_b, dut_sum), per-vector result pulse and
//                campaign status (counters, first error, busy, done)
module addr8s_result_checker
    import addr8s_pkg::*;
#(
    parameter int WIDTH = ADDR8S_WIDTH,
    parameter int CNT_W = ADDR8S_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    addr8s_result_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    state_t           state_reg, state_next;

    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] acc_reg;
    logic [CNT_W-1:0] acc_inc;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [WIDTH:0]   s1_sum_reg;

    logic             res_valid_reg;
    logic             res_mismatch_reg;
    logic [WIDTH:0]   res_diff_reg;

    logic [CNT_W-1:0] vec_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic             first_err_valid_reg;
    logic [CNT_W-1:0] first_err_idx_reg;

    logic             in_ready;
    logic             xfer;
    logic             start_ok;
    logic [WIDTH:0]   cmp_diff;
    logic             cmp_mismatch;

    assign acc_inc  = acc_reg + 1'b1;
    assign in_ready = (state_reg == RUN) && (acc_reg < target_reg);
    assign xfer     = bus.in_valid && in_ready;
    // start is only honoured between campaigns
    assign start_ok = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

    addr8s_golden_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .op_a     (s1_a_reg),
        .op_b     (s1_b_reg),
        .dut_sum  (s1_sum_reg),
        .diff     (cmp_diff),
        .mismatch (cmp_mismatch)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_next = (bus.target == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // leave on the edge that accepts the last vector
                if (xfer && (acc_inc == target_reg)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_reg && !res_valid_reg) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- pipeline and counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg          <= '0;
            acc_reg             <= '0;
            s1_valid_reg        <= 1'b0;
            s1_a_reg            <= '0;
            s1_b_reg            <= '0;
            s1_sum_reg          <= '0;
            res_valid_reg       <= 1'b0;
            res_mismatch_reg    <= 1'b0;
            res_diff_reg        <= '0;
            vec_cnt_reg         <= '0;
            err_cnt_reg         <= '0;
            first_err_valid_reg <= 1'b0;
            first_err_idx_reg   <= '0;
        end else begin
            s1_valid_reg  <= xfer;
            res_valid_reg <= s1_valid_reg;

            if (xfer) begin
                s1_a_reg   <= bus.op_a;
                s1_b_reg   <= bus.op_b;
                s1_sum_reg <= bus.dut_sum;
                acc_reg    <= acc_inc;
            end

            // start is only accepted with an empty pipeline, so it never
            // competes with a result update
            if (start_ok) begin
                target_reg          <= bus.target;
                acc_reg             <= '0;
                res_mismatch_reg    <= 1'b0;
                res_diff_reg        <= '0;
                vec_cnt_reg         <= '0;
                err_cnt_reg         <= '0;
                first_err_valid_reg <= 1'b0;
                first_err_idx_reg   <= '0;
            end else if (s1_valid_reg) begin
                res_diff_reg     <= cmp_diff;
                res_mismatch_reg <= cmp_mismatch;
                vec_cnt_reg      <= vec_cnt_reg + 1'b1;
                if (cmp_mismatch) begin
                    if (err_cnt_reg != CNT_ONES) begin
                        err_cnt_reg <= err_cnt_reg + 1'b1;
                    end
                    if (!first_err_valid_reg) begin
                        first_err_valid_reg <= 1'b1;
                        first_err_idx_reg   <= vec_cnt_reg;
                    end
                end
            end
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.res_valid       = res_valid_reg;
    assign bus.res_mismatch    = res_mismatch_reg;
    assign bus.res_diff        = res_diff_reg;
    assign bus.vec_cnt         = vec_cnt_reg;
    assign bus.err_cnt         = err_cnt_reg;
    assign bus.first_err_valid = first_err_valid_reg;
    assign bus.first_err_idx   = first_err_idx_reg;
    assign bus.busy            = (state_reg == RUN) || (state_reg == DRAIN);
    assign bus.done            = (state_reg == DONE);

endmodule
